rng_share_arbiter: RTL and testbench
====================================

// Module: rng_share_arbiter
// PURPOSE
// - Shares one 32-bit Fibonacci LFSR among NUM_REQ requesters, such as game-event timers and animation pickers.
// - Uses round-robin arbitration between requesters.
// - Returns to the granted requester a bounded random value in [0, limit].
// - Bounding uses masked rejection sampling with a deterministic fallback.
// - Sits between the tamagotchi game logic and its only entropy source.
// PARAMETERS
// NUM_REQ    4             number of requesters, 2..8
// OUT_W      8             result width, 1..32
// STEPS      8             LFSR decorrelation cycles per draw, >=1
// MAX_TRIES  4             draws before fallback, >=1
// SEED       32'hAAAAAAAA  LFSR reset value, must be nonzero
// PORTS
// clk       in   1                 clock; all logic on posedge
// rst       in   1                 synchronous, active-high reset
// ce        in   1                 clock enable; 0 freezes LFSR, FSM and outputs
// req       in   NUM_REQ           level request per requester; hold high until ack
// limit     in   NUM_REQ*OUT_W     inclusive upper bound; requester i uses [i*OUT_W +: OUT_W]
// ack       out  NUM_REQ           one-hot, one-cycle pulse; rnd_data valid in the same cycle
// rnd_data  out  OUT_W             result, held until the next ack
// gnt_id    out  clog2(NUM_REQ)    index of the current or last granted requester
// busy      out  1                 high in any state other than IDLE
// BEHAVIOUR
// - Reset (sync, highest priority):
//   - LFSR=SEED, state=IDLE, ack=0, rnd_data=0, gnt_id=0, busy=0.
//   - RR pointer=NUM_REQ-1, so requester 0 has priority first.
// - LFSR:
//   - Steps every cycle with ce=1, in every state.
//   - Update: q<={q[30:0],fb}.
//   - fb = XOR of q[31,29,28,27,23,20,19,17,15,14,12,11,9,4,3,2] (poly B89ADA1C).
//   - Sample = q[OUT_W-1:0].
// - mask = limit with all bits below its MSB set, i.e. the smallest 2^k-1 that is >= limit.
// - FSM (all transitions and registers qualified by ce):
//   - IDLE: if |req, grant the first set req after the RR pointer (wrapping).
//     - Latch gnt_id, limit and mask; tries=0; cnt=STEPS; go to DRAW.
//   - DRAW: decrement cnt each cycle; go to CHECK once cnt reaches 1, i.e. after STEPS cycles.
//   - CHECK: cand = sample & mask.
//     - If cand<=limit: rnd_data<=cand; go to ACK.
//     - Else if tries==MAX_TRIES-1: rnd_data<=cand-(limit+1); go to ACK. This is always <=limit because cand<2*(limit+1).
//     - Else: tries++; cnt=STEPS; go back to DRAW.
//   - ACK: ack[gnt_id]=1 for exactly this cycle; RR pointer<=gnt_id; go to IDLE. req is not sampled in ACK.
// - Latency: req seen in IDLE at cycle n gives ack at cycle n+STEPS+2 on first-try accept.
//   - Each retry adds STEPS+1 cycles.
//   - Worst case: n+MAX_TRIES*(STEPS+1)+1.
// - Abort: if req[gnt_id] falls in DRAW or CHECK, return to IDLE the next cycle.
//   - No ack; RR pointer and rnd_data unchanged.
// - Boundaries:
//   - limit=0: mask=0 and result is always 0.
//   - limit=all ones: mask=all ones and the first draw is always accepted.
//   - Requests from other requesters during a transaction wait; no queueing beyond level req.
//   - Simultaneous req on all lines: strict rotation 0,1,2,3,0,...
//   - rst mid-transaction: immediate return to reset state; no ack is issued.
//   - ce=0 at any point: every register holds; an ack pulse stays high until a ce=1 cycle passes.
// TESTING
// 1. Reset, then ce=1 for 1 cycle -> internal LFSR=32'h55555554; ack=0, busy=0, rnd_data=0.
// 2. req=4'b0001, limit0=8'hFF, STEPS=8 -> ack=4'b0001 exactly 10 cycles after req seen; rnd_data==golden-model LFSR[7:0].
// 3. req=4'b1111 held, re-raised after each ack -> ack order 0,1,2,3,0,1; gnt_id tracks; no requester starved.
// 4. limit0=0, 100 requests -> all rnd_data=0. limit0=8'd128, 1000 requests -> all rnd_data<=128; latency <= 4*9+1 cycles; fallback path hit at least once.
// 5. req0 dropped 3 cycles into DRAW -> no ack; busy=0 the next cycle; the next req1 is granted with gnt_id=1.
// 6. ce=0 for 5 cycles mid-DRAW, then rst pulse mid-CHECK -> state frozen while ce=0; after rst, all outputs equal reset values and no ack appears.

Source files
------------

// File: rtl/rng_share_if.sv
// rng_share_if: request/limit/ack bundle between requesters and the shared random source
interface rng_share_if #(
  parameter int NUM_REQ = 4,
  parameter int OUT_W   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*OUT_W-1:0] limit;
  logic [NUM_REQ-1:0]       ack;
  logic [OUT_W-1:0]         rnd_data;
  logic [ID_W-1:0]          gnt_id;
  logic                     busy;
  modport master(output req, limit, input ack, rnd_data, gnt_id, busy);
  modport slave(input req, limit, output ack, rnd_data, gnt_id, busy);
endinterface

// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: round-robin shared 32-bit LFSR returning bounded random values via masked rejection
module rng_share_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          OUT_W     = 8,
  parameter int          STEPS     = 8,
  parameter int          MAX_TRIES = 4,
  parameter logic [31:0] SEED      = 32'hAAAAAAAA
) (
  input logic       clk,
  input logic       rst,
  input logic       ce,
  rng_share_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW   = $clog2(STEPS + 1);
  localparam int TW   = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;
  typedef enum logic [1:0] {IDLE, DRAW, CHECK, ACK} state_t;
  state_t             state, state_n;
  logic [31:0]        lfsr;
  logic               fb;
  logic [ID_W-1:0]    ptr, ptr_n, gid, gid_n, win;
  logic [OUT_W-1:0]   lim_q, lim_n, mask_q, mask_n, data, data_n, sel_lim, cand;
  logic [CW-1:0]      cnt, cnt_n;
  logic [TW-1:0]      tries, tries_n;
  function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] v);
    logic [OUT_W-1:0] m;
    m = v;
    for (int s = 1; s < OUT_W; s = s * 2) m = m | (m >> s);
    return m;
  endfunction
  assign fb = ^{lfsr[31], lfsr[29], lfsr[28], lfsr[27], lfsr[23], lfsr[20], lfsr[19], lfsr[17],
                lfsr[15], lfsr[14], lfsr[12], lfsr[11], lfsr[9], lfsr[4], lfsr[3], lfsr[2]};
  assign cand = lfsr[OUT_W-1:0] & mask_q;
  assign sel_lim = bus.limit[win*OUT_W +: OUT_W];
  always_comb begin : nxt
    int j;
    win = '0;
    // descending scan so the lowest offset after the pointer wins
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(ptr) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (bus.req[j]) win = ID_W'(j);
    end
    state_n = state;
    ptr_n   = ptr;
    gid_n   = gid;
    lim_n   = lim_q;
    mask_n  = mask_q;
    cnt_n   = cnt;
    tries_n = tries;
    data_n  = data;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n = DRAW;
        gid_n   = win;
        lim_n   = sel_lim;
        mask_n  = smear(sel_lim);
        tries_n = '0;
        cnt_n   = CW'(STEPS);
      end
    end else if (state != ACK && !bus.req[gid]) begin
      state_n = IDLE;
    end else if (state == DRAW) begin
      cnt_n   = cnt - CW'(1);
      state_n = cnt == CW'(1) ? CHECK : DRAW;
    end else if (state == CHECK) begin
      if (cand <= lim_q) begin
        data_n  = cand;
        state_n = ACK;
      end else if (tries == TW'(MAX_TRIES - 1)) begin
        data_n  = cand - (lim_q + OUT_W'(1));
        state_n = ACK;
      end else begin
        tries_n = tries + TW'(1);
        cnt_n   = CW'(STEPS);
        state_n = DRAW;
      end
    end else begin
      ptr_n   = gid;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= SEED;
      ptr    <= ID_W'(NUM_REQ - 1);
      gid    <= '0;
      lim_q  <= '0;
      mask_q <= '0;
      cnt    <= '0;
      tries  <= '0;
      data   <= '0;
    end else if (ce) begin
      state  <= state_n;
      lfsr   <= {lfsr[30:0], fb};
      ptr    <= ptr_n;
      gid    <= gid_n;
      lim_q  <= lim_n;
      mask_q <= mask_n;
      cnt    <= cnt_n;
      tries  <= tries_n;
      data   <= data_n;
    end
  end
  assign bus.ack      = state == ACK ? NUM_REQ'(1) << gid : '0;
  assign bus.rnd_data = data;
  assign bus.gnt_id   = gid;
  assign bus.busy     = state != IDLE;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// tb_rng_share_arbiter: randomized transactions checked against a transaction-level LFSR/arbiter model
module tb_rng_share_arbiter;
  localparam int N = 4, W = 8, STEPS = 8, TRIES = 4;
  logic clk = 0, rst = 1, ce = 1;
  always #5 clk = ~clk;
  rng_share_if #(.NUM_REQ(N), .OUT_W(W)) bus();
  rng_share_arbiter #(.NUM_REQ(N), .OUT_W(W), .STEPS(STEPS), .MAX_TRIES(TRIES), .SEED(32'hAAAAAAAA))
    dut (.clk(clk), .rst(rst), .ce(ce), .bus(bus));
  int n_cmp = 0, n_bad = 0, rr = N - 1, nfb = 0;
  logic [31:0] m;
  logic [W-1:0] lim [N];
  logic [W-1:0] last_v = '0;
  function automatic logic [31:0] nxt(input logic [31:0] q);
    return {q[30:0], ^(q & 32'hB89ADA1C)};
  endfunction
  always @(posedge clk) m <= rst ? 32'hAAAAAAAA : ce ? nxt(m) : m;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    bus.req = '0;
    tick();
    tick();
    rst = 0;
    rr = N - 1;
  endtask
  task automatic predict(input logic [31:0] l0, input logic [W-1:0] li, output logic [W-1:0] v,
                         output int lat, output bit fb);
    int mk, c;
    logic [31:0] x;
    mk = 0;
    x = l0;
    fb = 0;
    v = '0;
    lat = 0;
    while (mk < int'(li)) mk = mk * 2 + 1;
    for (int t = 0; t < TRIES; t++) begin
      for (int s = 0; s <= STEPS; s++) x = nxt(x);
      c = int'(x[W-1:0]) & mk;
      lat = (STEPS + 1) * (t + 1) + 1;
      if (c <= int'(li)) begin
        v = W'(c);
        return;
      end
      if (t == TRIES - 1) begin
        v = W'(c - int'(li) - 1);
        fb = 1;
      end
    end
  endtask
  task automatic txn(input logic [N-1:0] r, output int lat_o, output int g);
    int w, lat, cyc;
    logic [W-1:0] v;
    bit fb;
    w = -1;
    bus.req = r;
    for (int i = 0; i < N; i++) bus.limit[i*W +: W] = lim[i];
    for (int k = 1; k <= N; k++) if (w < 0 && r[(rr + k) % N]) w = (rr + k) % N;
    predict(m, lim[w], v, lat, fb);
    if (fb) nfb++;
    cyc = 0;
    while (bus.ack == '0 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("ack_vec", bus.ack, 1 << w);
    chk("latency", cyc, lat);
    chk("rnd_data", bus.rnd_data, v);
    chk("gnt_id", bus.gnt_id, w);
    last_v = v;
    lat_o = cyc;
    g = int'(bus.gnt_id);
    bus.req[w] = 1'b0;
    tick();
    chk("ack_pulse", bus.ack, 0);
    rr = w;
  endtask
  initial begin
    int lat, g, n_ack;
    bus.req = '0;
    bus.limit = '0;
    for (int i = 0; i < N; i++) lim[i] = '0;
    do_reset();
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rnd", bus.rnd_data, 0);
    chk("rst_gnt", bus.gnt_id, 0);
    chk("rst_lfsr", dut.lfsr, 32'hAAAAAAAA);
    tick();
    chk("lfsr_step1", dut.lfsr, 32'h55555554);
    chk("idle_busy", bus.busy, 0);
    chk("idle_ack", bus.ack, 0);
    lim[0] = 8'hFF;
    txn(4'b0001, lat, g);
    chk("first_lat", lat, STEPS + 2);
    do_reset();
    for (int i = 0; i < N; i++) lim[i] = W'($urandom);
    for (int k = 0; k < 6; k++) begin
      txn(4'b1111, lat, g);
      chk("rr_order", g, k % N);
    end
    lim[0] = 8'd0;
    for (int k = 0; k < 100; k++) begin
      txn(4'b0001, lat, g);
      chk("lim0_zero", bus.rnd_data, 0);
    end
    lim[0] = 8'd128;
    nfb = 0;
    for (int k = 0; k < 1000; k++) begin
      txn(4'b0001, lat, g);
      chk("bounded", bus.rnd_data <= 8'd128, 1);
      chk("lat_bound", lat <= TRIES * (STEPS + 1) + 1, 1);
    end
    chk("fallback_hit", nfb > 0, 1);
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < N; i++) lim[i] = W'($urandom);
      txn(N'($urandom_range(1, 15)), lat, g);
    end
    lim[0] = W'($urandom);
    bus.limit[0 +: W] = lim[0];
    bus.req = 4'b0001;
    tick();
    chk("abort_busy_on", bus.busy, 1);
    for (int k = 0; k < 3; k++) tick();
    bus.req = '0;
    tick();
    chk("abort_busy_off", bus.busy, 0);
    chk("abort_rnd_held", bus.rnd_data, last_v);
    n_ack = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.ack != '0) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    lim[1] = W'($urandom);
    txn(4'b0010, lat, g);
    chk("after_abort_gnt", g, 1);
    lim[0] = 8'hFF;
    bus.limit[0 +: W] = lim[0];
    bus.req = 4'b0001;
    tick();
    for (int k = 0; k < 3; k++) tick();
    ce = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("frz_busy", bus.busy, 1);
      chk("frz_ack", bus.ack, 0);
      chk("frz_lfsr", dut.lfsr, m);
    end
    ce = 1;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst_ack", bus.ack, 0);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1;
    bus.req = '0;
    tick();
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rnd", bus.rnd_data, 0);
    chk("mid_rst_gnt", bus.gnt_id, 0);
    chk("mid_rst_lfsr", dut.lfsr, 32'hAAAAAAAA);
    rst = 0;
    rr = N - 1;
    n_ack = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.ack != '0) n_ack++;
    end
    chk("post_rst_no_ack", n_ack, 0);
    lim[2] = W'($urandom);
    txn(4'b0100, lat, g);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
